btn_event_sched: RTL and testbench
==================================

// Module: btn_event_sched
// PURPOSE
//   Shared debounce scheduler for NB front-panel buttons. One prescaler generates a
//   single-cycle tick every 2^N clk cycles. On each tick a scan FSM visits the
//   buttons one per cycle and updates each button's debounce state. The resulting
//   press, release and long-press events go into a small FIFO, which is drained
//   through a valid/ready handshake. Sits between raw board switches and control logic.
// PARAMETERS
//   NB          4    number of buttons (>=2)
//   N           20   prescaler bits; tick period = 2^N clk (20ns clk -> ~21ms). Require 2^N >= NB+2
//   DB_TICKS    3    consecutive differing ticks needed to flip a debounced level (>=1)
//   LONG_TICKS  100  ticks a debounced press must last before one long-press event
//   FIFO_DEPTH  4    event FIFO entries, power of 2
// PORTS
//   clk       in   1              system clock; every flop is in this domain, no derived clocks
//   reset     in   1              asynchronous, active-low reset (0 = reset)
//   sw        in   NB             raw asynchronous switch inputs
//   db        out  NB             debounced levels
//   tick      out  1              prescaler tick, 1 clk wide
//   ev_valid  out  1              FIFO head valid (= not empty)
//   ev_ready  in   1              consumer accepts head when ev_valid & ev_ready
//   ev_id     out  clog2(NB)      button index of head event
//   ev_code   out  2              01 press, 10 release, 11 long-press (00 never output)
//   overflow  out  1              sticky: an event was dropped
//   clr_ovf   in   1              synchronous clear of overflow
// BEHAVIOUR
// - Reset (reset=0, async): db=0, tick=0, prescaler=0, all per-button counters and flags 0,
//   FIFO empty (ev_valid=0, ev_id=0, ev_code=0), overflow=0, FSM=IDLE. A mid-scan reset aborts the scan.
// - sw passes through a 2-flop synchronizer (s[i]). Each scan visit samples s[i] as it is in that cycle.
// - Prescaler: q increments every clk and wraps. tick=1 in the cycle where q==2^N-1.
// - FSM IDLE -> SCAN on tick with idx=0. SCAN visits idx, then idx+1.
//   After visiting idx=NB-1 it returns to IDLE. A scan takes NB cycles; the constraint rules out overlap.
// - Per-button visit i, with s=s[i], d=db[i], cnt in 0..DB_TICKS-1, hold and long_sent:
//   s!=d: if cnt==DB_TICKS-1 -> db[i]<=s, cnt<=0, hold<=0, long_sent<=0, push press (s=1) or release (s=0);
//         else cnt<=cnt+1
//   s==d: cnt<=0; if d=1 & !long_sent: hold<=hold+1;
//         when hold+1==LONG_TICKS -> push long-press, long_sent<=1
//   db[i] changes on the clk edge that ends its visit cycle. At most one push per cycle.
// - Event order: by tick, then by ascending button index within a scan.
// - FIFO is show-ahead: ev_id/ev_code are valid while ev_valid=1 and hold steady until popped.
//   Pop = ev_valid & ev_ready.
// - Push while full: if a pop happens in the same cycle, the push succeeds.
//   Otherwise the event is dropped and overflow<=1. db and counters still update.
// - Push and pop in the same cycle when not full: occupancy is unchanged. A push into an empty
//   FIFO raises ev_valid in the next cycle.
// - overflow: set has priority over clr_ovf in the same cycle.
// - Widths: cnt is clog2(DB_TICKS+1) bits; hold is clog2(LONG_TICKS+1) bits and does not
//   count once long_sent=1. The FIFO pointers carry one extra wrap bit for the full/empty test.
// TESTING (N=4, NB=4, DB_TICKS=3, LONG_TICKS=5, FIFO_DEPTH=4)
// - Assert reset mid-operation -> db=0, ev_valid=0, overflow=0, tick=0 immediately (async); resumes cleanly on release.
// - sw[2]=1 held 3 ticks -> db[2]=1 after visit 2 of the third scan; one event {id=2, code=01}; no other events.
// - sw[1]=1 for 2 ticks then 0 (bounce) -> db[1] stays 0, no event, cnt back to 0.
// - sw[0] pressed and held 10 ticks past debounce -> exactly one {0,11} after 5 ticks; release -> {0,10}.
// - ev_ready=0, all sw rise together -> 4 events {0,01},{1,01},{2,01},{3,01} in order, FIFO full; release of sw[0] -> dropped, overflow=1 until clr_ovf.
// - FIFO full, ev_ready=1 in the same cycle as a push -> no drop, occupancy stays 4, order preserved.

Source files
------------

// File: rtl/btn_event_sched.sv
// btn_event_sched: shared debounce scheduler for a bank of front-panel buttons.
// A free-running prescaler emits a one-cycle tick; each tick launches a scan
// that visits one button per cycle, updates that button's debounce state and
// may emit a press / release / long-press event into a small show-ahead FIFO.
module btn_event_sched #(
  parameter int NB         = 4,
  parameter int N          = 20,
  parameter int DB_TICKS   = 3,
  parameter int LONG_TICKS = 100,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NB-1:0]         sw,
  output logic [NB-1:0]         db,
  output logic                  tick,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic [$clog2(NB)-1:0] ev_id,
  output logic [1:0]            ev_code,
  output logic                  overflow,
  input  logic                  clr_ovf
);

  localparam int IW = $clog2(NB);
  localparam int CW = $clog2(DB_TICKS + 1);
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = IW + 2;

  localparam logic [CW-1:0] CNT_LAST  = CW'(DB_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NB - 1);

  localparam logic [1:0] CODE_PRESS   = 2'b01;
  localparam logic [1:0] CODE_RELEASE = 2'b10;
  localparam logic [1:0] CODE_LONG    = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer and prescaler
  // ---------------------------------------------------------------------------
  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [N-1:0]  q;

  // Two-flop synchronizer for the raw, asynchronous switch levels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
    end
  end

  // Free-running prescaler; wraps naturally at 2^N.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else begin
      q <= q + N'(1);
    end
  end

  // Tick marks the last count of the prescaler period (q is zero in reset).
  assign tick = &q;

  // ---------------------------------------------------------------------------
  // Scan FSM: one button visited per cycle after each tick
  // ---------------------------------------------------------------------------
  state_t        state;
  state_t        state_next;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_next;
  logic          visiting;

  // State register for the scan sequencer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Next-state logic: start on tick, step the index, return to IDLE after the last button.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    visiting   = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          state_next = SCAN;
          idx_next   = '0;
        end
      end
      SCAN: begin
        visiting = 1'b1;
        if (idx == IDX_LAST) begin
          state_next = IDLE;
          idx_next   = '0;
        end else begin
          idx_next = idx + IW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shared visit datapath: one debounce update per cycle for button idx
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt_arr  [NB];
  logic [HW-1:0] hold_arr [NB];
  logic [NB-1:0] ls_arr;

  logic          s_cur;
  logic          d_cur;
  logic [CW-1:0] cnt_cur;
  logic [HW-1:0] hold_cur;
  logic          ls_cur;
  logic [HW-1:0] hold_inc;

  logic          d_next;
  logic [CW-1:0] cnt_next;
  logic [HW-1:0] hold_next;
  logic          ls_next;
  logic          push;
  logic [1:0]    push_code;

  // Debounce rules for the visited button; produces its next state and at most one event.
  always_comb begin
    s_cur     = sync2[idx];
    d_cur     = db[idx];
    cnt_cur   = cnt_arr[idx];
    hold_cur  = hold_arr[idx];
    ls_cur    = ls_arr[idx];
    hold_inc  = hold_cur + HW'(1);
    d_next    = d_cur;
    cnt_next  = cnt_cur;
    hold_next = hold_cur;
    ls_next   = ls_cur;
    push      = 1'b0;
    push_code = 2'b00;
    if (visiting) begin
      if (s_cur != d_cur) begin
        if (cnt_cur == CNT_LAST) begin
          // Input has differed for enough ticks: flip the level and report it.
          d_next    = s_cur;
          cnt_next  = '0;
          hold_next = '0;
          ls_next   = 1'b0;
          push      = 1'b1;
          push_code = s_cur ? CODE_PRESS : CODE_RELEASE;
        end else begin
          cnt_next = cnt_cur + CW'(1);
        end
      end else begin
        // Agreement resets the disagreement run; a held press ages toward long-press.
        cnt_next = '0;
        if (d_cur && !ls_cur) begin
          hold_next = hold_inc;
          if (hold_inc == HOLD_LAST) begin
            push      = 1'b1;
            push_code = CODE_LONG;
            ls_next   = 1'b1;
          end
        end
      end
    end
  end

  // Per-button state storage; only the button currently being visited loads.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_btn
      logic          sel;
      logic          db_r;
      logic [CW-1:0] cnt_r;
      logic [HW-1:0] hold_r;
      logic          ls_r;

      assign sel = visiting && (idx == IW'(gi));

      // Load the shared datapath result into this button's state on its visit.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          db_r   <= 1'b0;
          cnt_r  <= '0;
          hold_r <= '0;
          ls_r   <= 1'b0;
        end else if (sel) begin
          db_r   <= d_next;
          cnt_r  <= cnt_next;
          hold_r <= hold_next;
          ls_r   <= ls_next;
        end
      end

      assign db[gi]       = db_r;
      assign cnt_arr[gi]  = cnt_r;
      assign hold_arr[gi] = hold_r;
      assign ls_arr[gi]   = ls_r;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Event FIFO (show-ahead) and overflow flag
  // ---------------------------------------------------------------------------
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic [EW-1:0] head;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop     = ev_valid & ev_ready;
  // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  // Read and write pointers, each with a wrap bit to separate full from empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + (AW+1)'(1);
      end
      if (pop) begin
        rptr <= rptr + (AW+1)'(1);
      end
    end
  end

  // Event storage; contents are only observed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr[AW-1:0]] <= {idx, push_code};
    end
  end

  // Sticky overflow; a drop in the same cycle wins over a clear request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  assign head     = mem[rptr[AW-1:0]];
  assign ev_valid = ~empty;
  assign ev_id    = ev_valid ? head[EW-1:2] : '0;
  assign ev_code  = ev_valid ? head[1:0]    : 2'b00;

endmodule

// File: tb/tb_btn_event_sched.sv
// Testbench for btn_event_sched: directed button scenarios plus random switch
// activity, checked cycle by cycle against a behavioural reference model and
// an event scoreboard drained by an independent monitor.
module tb_btn_event_sched;

  localparam int NB  = 4;
  localparam int N   = 4;
  localparam int DB  = 3;
  localparam int LT  = 5;
  localparam int FD  = 4;
  localparam int PER = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NB-1:0] sw = '0;
  logic          ev_ready = 1'b0;
  logic          clr_ovf = 1'b0;
  logic [NB-1:0] db;
  logic          tick;
  logic          ev_valid;
  logic [1:0]    ev_id;
  logic [1:0]    ev_code;
  logic          overflow;

  btn_event_sched #(
    .NB(NB), .N(N), .DB_TICKS(DB), .LONG_TICKS(LT), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw), .db(db), .tick(tick),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_id(ev_id), .ev_code(ev_code),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int n_pop   = 0;

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0] id;
    logic [1:0] code;
  } ev_t;

  ev_t           exp_q[$];
  int            m_q;
  bit            m_armed;
  bit [NB-1:0]   m_s1, m_s2, m_db;
  int            m_cnt[NB];
  int            m_hold[NB];
  bit            m_ls[NB];
  int            m_occ;
  bit            m_ovf;

  task automatic model_reset();
    m_q = 0; m_armed = 0; m_s1 = '0; m_s2 = '0; m_db = '0;
    for (int i = 0; i < NB; i++) begin
      m_cnt[i] = 0; m_hold[i] = 0; m_ls[i] = 0;
    end
    m_occ = 0; m_ovf = 0;
    exp_q.delete();
  endtask

  // One clock cycle of the specified behaviour, using the inputs seen at the edge.
  task automatic model_step();
    bit pop_m, push_m, acc;
    int code, b;
    ev_t e;
    pop_m  = (m_occ > 0) && ev_ready;
    push_m = 0;
    code   = 0;
    b      = m_q;
    if (m_armed && m_q < NB) begin
      if (m_s2[b] != m_db[b]) begin
        if (m_cnt[b] == DB - 1) begin
          m_db[b] = m_s2[b]; m_cnt[b] = 0; m_hold[b] = 0; m_ls[b] = 0;
          push_m = 1; code = m_s2[b] ? 1 : 2;
        end else begin
          m_cnt[b]++;
        end
      end else begin
        m_cnt[b] = 0;
        if (m_db[b] && !m_ls[b]) begin
          m_hold[b]++;
          if (m_hold[b] == LT) begin
            push_m = 1; code = 3; m_ls[b] = 1;
          end
        end
      end
    end
    if (m_q == PER - 1) m_armed = 1;
    acc = push_m && (m_occ < FD || pop_m);
    if (acc) begin
      e.id = 2'(b); e.code = 2'(code);
      exp_q.push_back(e);
    end
    if (push_m && !acc) m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
    m_occ = m_occ + int'(acc) - int'(pop_m);
    m_s2 = m_s1;
    m_s1 = sw;
    m_q = (m_q + 1) % PER;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!reset) model_reset();
      else model_step();
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      #1;
      check("db", int'(db), int'(m_db));
      check("tick", int'(tick), int'(m_q == PER - 1));
      check("ev_valid", int'(ev_valid), int'(m_occ > 0));
      check("overflow", int'(overflow), int'(m_ovf));
      if (ev_valid && ev_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL unexpected_event: got id=%0d code=%0d, expected none", ev_id, ev_code);
        end else begin
          e = exp_q.pop_front();
          check("ev_id", int'(ev_id), int'(e.id));
          check("ev_code", int'(ev_code), int'(e.code));
          $display("event id=%0d code=%0d t=%0t", ev_id, ev_code, $time);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick();
    for (int k = 0; k < 4 * PER; k++) begin
      @(negedge clk);
      if (tick) return;
    end
    vectors++; errors++;
    $display("FAIL wait_tick: got no tick, expected one within %0d cycles", 4 * PER);
  endtask

  // Change switches just after a scan has finished.
  task automatic set_sw(logic [NB-1:0] v);
    wait_tick();
    cycles(6);
    sw = v;
  endtask

  task automatic random_run(int ncyc);
    int mode = 0;
    int b;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (c % 200 == 0) mode = $urandom_range(0, 2);
      ev_ready = (mode == 0) ? ($urandom_range(0, 3) != 0) :
                 (mode == 1) ? ($urandom_range(0, 7) == 0) : 1'b1;
      clr_ovf  = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 39) == 0) begin
        b = $urandom_range(0, NB - 1);
        sw[b] = ~sw[b];
      end
    end
    clr_ovf = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int p0, t;

    // Reset state
    cycles(3);
    check("rst_db", int'(db), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_ev_valid", int'(ev_valid), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_ev_id", int'(ev_id), 0);
    check("rst_ev_code", int'(ev_code), 0);
    reset = 1'b1;
    ev_ready = 1'b1;

    // Tick period
    wait_tick();
    t = 0;
    for (int k = 0; k < 4 * PER; k++) begin
      @(negedge clk);
      t++;
      if (tick) break;
    end
    check("tick_period", t, PER);

    // Clean press and release of button 2
    p0 = n_pop;
    set_sw(4'b0100);
    repeat (4) wait_tick();
    check("db2_pressed", int'(db[2]), 1);
    check("press2_events", n_pop - p0, 1);
    set_sw(4'b0000);
    repeat (4) wait_tick();
    check("release2_events", n_pop - p0, 2);

    // Two bounces on button 1: neither may flip it (counter must clear in between)
    p0 = n_pop;
    repeat (2) begin
      set_sw(4'b0010);
      wait_tick();
      cycles(6);
      sw = 4'b0000;
    end
    repeat (3) wait_tick();
    check("bounce_db1", int'(db[1]), 0);
    check("bounce_events", n_pop - p0, 0);

    // Long press on button 0, then release
    p0 = n_pop;
    set_sw(4'b0001);
    repeat (3 + 10) wait_tick();
    check("long_events", n_pop - p0, 2);
    set_sw(4'b0000);
    repeat (4) wait_tick();
    check("long_release_events", n_pop - p0, 3);

    // All buttons pressed with the consumer stalled: FIFO fills, then a drop
    cycles(2);
    ev_ready = 1'b0;
    set_sw(4'b1111);
    repeat (4) wait_tick();
    check("full_valid", int'(ev_valid), 1);
    set_sw(4'b1110);
    repeat (4) wait_tick();
    check("drop_overflow", int'(overflow), 1);
    cycles(1);
    clr_ovf = 1'b1;
    cycles(1);
    clr_ovf = 1'b0;
    cycles(1);
    check("ovf_cleared", int'(overflow), 0);

    // FIFO full, pop coincides with button 1's release push
    set_sw(4'b1100);
    wait_tick();
    wait_tick();
    wait_tick();
    @(negedge clk);
    @(negedge clk);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    check("simul_push_pop_valid", int'(ev_valid), 1);
    cycles(2);

    // Drain, then random activity
    sw = '0;
    ev_ready = 1'b1;
    cycles(20 * PER);
    check("drained", exp_q.size(), 0);
    random_run(1600);

    // Asynchronous reset in the middle of a scan with state populated
    ev_ready = 1'b0;
    set_sw(4'b1011);
    repeat (4) wait_tick();
    wait_tick();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_db", int'(db), 0);
    check("mid_rst_ev_valid", int'(ev_valid), 0);
    check("mid_rst_overflow", int'(overflow), 0);
    check("mid_rst_tick", int'(tick), 0);
    cycles(3);
    reset = 1'b1;
    random_run(800);

    sw = '0;
    ev_ready = 1'b1;
    cycles(20 * PER);
    check("final_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
